// File: rtl/adc2_cfg_pkg.sv
// Shared types and constants for the ADC2 configuration sequencer:
// FSM state encoding, SPI word width and the default register table.
package adc2_cfg_pkg;

    localparam int ADC2_WORD_W      = 24;
    localparam int ADC2_TABLE_DEPTH = 32;
    localparam int ADC2_TIDX_W      = 5;

    typedef enum logic [1:0] {
        POR_WAIT = 2'd0,
        SEND     = 2'd1,
        WAIT     = 2'd2,
        READY    = 2'd3
    } adc2_state_t;

    // Entries beyond the active NUM_REGS are never sent; they read as zero.
    localparam logic [ADC2_WORD_W-1:0] ADC2_CFG_TABLE [ADC2_TABLE_DEPTH] = '{
        24'h000001, 24'h010080, 24'h020003, 24'h03001F,
        24'h041200, 24'h050A00, 24'h06FF00, 24'h0700C3,
        24'h000000, 24'h000000, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000
    };

endpackage

// File: rtl/adc2_cfg_rom.sv
// Combinational lookup of the default ADC2 register table: idx -> 24-bit word.
module adc2_cfg_rom
    import adc2_cfg_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3
) (
    input  logic [IDX_W-1:0]       idx,
    output logic [ADC2_WORD_W-1:0] word
);

    logic [ADC2_TIDX_W-1:0] tidx;

    always_comb begin
        tidx = ADC2_TIDX_W'(idx);
        word = '0;
        if (int'(idx) < NUM_REGS) begin
            word = ADC2_CFG_TABLE[tidx];
        end
    end

endmodule

// File: rtl/adc2_cfg_ctrl.sv
// ADC2 configuration sequencer: power-on delay, table walk over the SPI writer,
// then single host writes. Optional ADC2_HWRST_EN adds the adc_rst_n output.
module adc2_cfg_ctrl
    import adc2_cfg_pkg::*;
#(
    parameter int NUM_REGS   = 8,
    parameter int SPI_LEN    = 24,
    parameter int GAP_CYCLES = 4,
    parameter int POR_DELAY  = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   wr_req,
    input  logic [ADC2_WORD_W-1:0] wr_data,
    output logic                   wr_ack,
    output logic                   send,
    output logic [ADC2_WORD_W-1:0] pattern,
    output logic                   busy,
    output logic                   init_done
`ifdef ADC2_HWRST_EN
    ,
    output logic                   adc_rst_n
`endif
);

    localparam int FRAME_CYC = SPI_LEN + GAP_CYCLES;
    localparam int POR_W     = (POR_DELAY > 1) ? $clog2(POR_DELAY) : 1;
    localparam int WCNT_W    = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
    localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [POR_W-1:0]  POR_LAST  = POR_W'(POR_DELAY - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(FRAME_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REGS - 1);

    adc2_state_t            state;
    logic [POR_W-1:0]       por_cnt;
    logic [WCNT_W-1:0]      wcnt;
    logic [IDX_W-1:0]       idx;
    logic                   host_frm;
    logic [IDX_W-1:0]       rom_idx;
    logic [ADC2_WORD_W-1:0] rom_word;

    // Look up the word for the frame about to launch, so pattern is valid in the send cycle.
    always_comb begin
        rom_idx = '0;
        if (state == WAIT) begin
            rom_idx = idx + IDX_W'(1);
        end
    end

    adc2_cfg_rom #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_rom (
        .idx  (rom_idx),
        .word (rom_word)
    );

    // Ack is decoded in the accepting READY cycle so it leads send by exactly one cycle.
    assign wr_ack = (state == READY) && !start && wr_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= POR_WAIT;
            por_cnt   <= '0;
            wcnt      <= '0;
            idx       <= '0;
            host_frm  <= 1'b0;
            send      <= 1'b0;
            pattern   <= '0;
            busy      <= 1'b1;
            init_done <= 1'b0;
`ifdef ADC2_HWRST_EN
            adc_rst_n <= 1'b0;
`endif
        end else begin
            send <= 1'b0;
            case (state)
                POR_WAIT: begin
`ifdef ADC2_HWRST_EN
                    if (por_cnt == POR_W'(POR_DELAY / 2 - 1)) begin
                        adc_rst_n <= 1'b1;
                    end
`endif
                    if (por_cnt == POR_LAST) begin
                        por_cnt  <= '0;
                        idx      <= '0;
                        host_frm <= 1'b0;
                        pattern  <= rom_word;
                        send     <= 1'b1;
                        state    <= SEND;
                    end else begin
                        por_cnt <= por_cnt + POR_W'(1);
                    end
                end
                SEND: begin
                    wcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (wcnt == WCNT_LAST) begin
                        wcnt <= '0;
                        if (host_frm) begin
                            busy  <= 1'b0;
                            state <= READY;
                        end else if (idx == IDX_LAST) begin
                            init_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= READY;
                        end else begin
                            idx     <= idx + IDX_W'(1);
                            pattern <= rom_word;
                            send    <= 1'b1;
                            state   <= SEND;
                        end
                    end else begin
                        wcnt <= wcnt + WCNT_W'(1);
                    end
                end
                READY: begin
                    if (start) begin
                        init_done <= 1'b0;
                        idx       <= '0;
                        host_frm  <= 1'b0;
                        pattern   <= rom_word;
                        send      <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end else if (wr_req) begin
                        host_frm <= 1'b1;
                        pattern  <= wr_data;
                        send     <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                default: state <= POR_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_adc2_cfg_ctrl.sv
// Directed/randomized bench for adc2_cfg_ctrl with an expected-frame schedule model.
module tb_adc2_cfg_ctrl;

    localparam int POR  = 16;
    localparam int NREG = 8;
    localparam int FRM  = 28;   // SPI_LEN + GAP_CYCLES cycles of WAIT after each send

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        wr_req = 1'b0;
    logic [23:0] wr_data = '0;
    logic        wr_ack;
    logic        send;
    logic [23:0] pattern;
    logic        busy;
    logic        init_done;
`ifdef ADC2_HWRST_EN
    logic        adc_rst_n;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [23:0] ref_table [NREG] = '{
        24'h000001, 24'h010080, 24'h020003, 24'h03001F,
        24'h041200, 24'h050A00, 24'h06FF00, 24'h0700C3
    };
    logic [23:0] exp_q [$];

    adc2_cfg_ctrl #(
        .NUM_REGS   (NREG),
        .SPI_LEN    (24),
        .GAP_CYCLES (4),
        .POR_DELAY  (POR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .send      (send),
        .pattern   (pattern),
        .busy      (busy),
        .init_done (init_done)
`ifdef ADC2_HWRST_EN
        ,
        .adc_rst_n (adc_rst_n)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " send"}, send, 0);
        chk({tag, " wr_ack"}, wr_ack, 0);
        chk({tag, " pattern"}, pattern, 0);
        chk({tag, " busy"}, busy, 1);
        chk({tag, " init_done"}, init_done, 0);
`ifdef ADC2_HWRST_EN
        chk({tag, " adc_rst_n"}, adc_rst_n, 0);
`endif
    endtask

    task automatic chk_ready(input string tag, input logic exp_ack);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " init_done"}, init_done, 1);
        chk({tag, " send"}, send, 0);
        chk({tag, " wr_ack"}, wr_ack, exp_ack);
    endtask

    // Checks cycles 0..POR-1 after release; returns positioned on the first send cycle.
    task automatic por_phase(input string tag);
        for (int c = 0; c < POR; c++) begin
            chk({tag, " send"}, send, 0);
            chk({tag, " busy"}, busy, 1);
            chk({tag, " pattern"}, pattern, 0);
`ifdef ADC2_HWRST_EN
            chk({tag, " adc_rst_n"}, adc_rst_n, (c >= POR / 2) ? 1 : 0);
`endif
            if ($urandom_range(5) == 0) start = 1'b1;
            step();
        end
    endtask

    // One frame starting at its send cycle; a full frame ends on the following cycle.
    task automatic frame(input logic [23:0] w, input logic done, input int nwait, input string tag);
        chk({tag, " send"}, send, 1);
        chk({tag, " pattern"}, pattern, w);
        chk({tag, " busy"}, busy, 1);
        chk({tag, " wr_ack"}, wr_ack, 0);
        chk({tag, " init_done"}, init_done, done);
        for (int i = 0; i < nwait; i++) begin
            if ($urandom_range(7) == 0) start = 1'b1;
            step();
            chk({tag, " wait send"}, send, 0);
            chk({tag, " wait pattern"}, pattern, w);
            chk({tag, " wait busy"}, busy, 1);
            chk({tag, " wait wr_ack"}, wr_ack, 0);
            chk({tag, " wait init_done"}, init_done, done);
        end
        if (nwait == FRM) step();
    endtask

    task automatic load_table();
        for (int k = 0; k < NREG; k++) exp_q.push_back(ref_table[k]);
    endtask

    task automatic play_frames(input logic done, input string tag);
        while (exp_q.size() > 0) begin
            frame(exp_q.pop_front(), done, FRM, tag);
        end
    endtask

    task automatic host_write(input logic [23:0] w, input string tag);
        wr_data = w;
        wr_req  = 1'b1;
        #1;
        chk({tag, " ack"}, wr_ack, 1);
        chk({tag, " ack busy"}, busy, 0);
        step();
        wr_req = 1'b0;
        frame(w, 1'b1, FRM, tag);
        chk_ready({tag, " ready"}, 1'b0);
    endtask

    task automatic ready_idle(input string tag);
        int n;
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) begin
            chk_ready(tag, 1'b0);
            step();
        end
    endtask

    initial begin
        logic [23:0] rnd;
        int cut;

        repeat (3) @(negedge clk);
        #1;
        chk_reset("reset");

        rst_n = 1'b1;
        por_phase("por1");
        load_table();
        play_frames(1'b0, "init");
        chk_ready("init_done", 1'b0);
        ready_idle("idle1");

        host_write(24'h000A5C, "host5c");
        for (int r = 0; r < 3; r++) begin
            ready_idle("idle2");
            host_write(24'($urandom), "hostrnd");
        end

        // start and wr_req together: table replays first, host word queued behind it
        wr_data = 24'h123456;
        wr_req  = 1'b1;
        start   = 1'b1;
        #1;
        chk("start_wins ack", wr_ack, 0);
        step();
        load_table();
        exp_q.push_back(24'h123456);
        for (int k = 0; k < NREG; k++) frame(exp_q.pop_front(), 1'b0, FRM, "replay");
        chk_ready("replay done", 1'b1);
        step();
        wr_req = 1'b0;
        frame(exp_q.pop_front(), 1'b1, FRM, "pending");
        chk_ready("pending ready", 1'b0);

        // host request raised mid-sequence with random data
        start = 1'b1;
        step();
        load_table();
        frame(exp_q.pop_front(), 1'b0, FRM, "mid0");
        rnd     = 24'($urandom);
        wr_data = rnd;
        wr_req  = 1'b1;
        play_frames(1'b0, "mid");
        chk_ready("mid done", 1'b1);
        step();
        wr_req = 1'b0;
        frame(rnd, 1'b1, FRM, "midhost");
        chk_ready("midhost ready", 1'b0);

        // asynchronous reset during the third frame's WAIT
        start = 1'b1;
        step();
        frame(ref_table[0], 1'b0, FRM, "rst0");
        frame(ref_table[1], 1'b0, FRM, "rst1");
        cut = $urandom_range(1, FRM - 1);
        frame(ref_table[2], 1'b0, cut, "rst2");
        #1 rst_n = 1'b0;
        #1;
        chk_reset("async_reset");
        step();
        step();
        chk_reset("held_reset");
        rst_n = 1'b1;
        por_phase("por2");
        frame(ref_table[0], 1'b0, FRM, "restart0");
        frame(ref_table[1], 1'b0, FRM, "restart1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
